// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM soft-start controller: FSM encoding and ramp limits.
// The ramp generator and the bench use the same constants.
package pwm_ctrl_pkg;

    localparam int RAMP_W = 8;
    localparam logic [RAMP_W-1:0] RAMP_MAX = '1;

    // Period counter width; covers PERIODS_PER_STEP up to 255.
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

endpackage

// File: rtl/pwm_step_tick.sv
// Period-end detector plus divide-by-PERIODS_PER_STEP counter.
// tick fires on every PERIODS_PER_STEP-th ramp wrap while run is high.
module pwm_step_tick
    import pwm_ctrl_pkg::*;
#(
    parameter int WIDTH            = 8,
    parameter int PERIODS_PER_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [WIDTH-1:0] ramp,
    output logic             tick
);

    localparam logic [WIDTH-1:0] RAMP_TOP = '1;

    logic [CNT_W-1:0] cnt;
    logic             period_end;

    assign period_end = (ramp == RAMP_TOP);
    assign tick       = run && period_end && (cnt == CNT_W'(PERIODS_PER_STEP - 1));

    // Dropping run clears the count, so each running state starts a fresh step interval.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt <= '0;
        end else if (period_end) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_softstart_ctrl.sv
// Soft-start / soft-stop duty reference controller for a PWM comparator.
// Ramps ref_out toward a latched target one step per update tick; fault forces zero at once.
module pwm_softstart_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int WIDTH            = 8,
    parameter int PERIODS_PER_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] ramp,
    input  logic             fault,
    output logic [WIDTH-1:0] ref_out,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state
);

    state_t           st_q, st_n;
    logic [WIDTH-1:0] ref_q, ref_n, tgt_q, tgt_n, stp_q, stp_n;
    logic             stop_q, stop_n, done_q, done_n;
    logic             tick, run, running, en_change;
    logic [WIDTH-1:0] step_eff, floor_v;
    logic [WIDTH:0]   up_sum, down_lim;

    assign running  = (st_q == ST_RAMP_UP) || (st_q == ST_HOLD) || (st_q == ST_RAMP_DOWN);
    // en-driven moves between running states also restart the step interval.
    assign en_change = (((st_q == ST_RAMP_UP) || (st_q == ST_HOLD)) && !en)
                     || ((st_q == ST_RAMP_DOWN) && en && stop_q);
    assign run      = running && !fault && !en_change;

    assign step_eff = (step == '0) ? WIDTH'(1) : step;
    assign floor_v  = en ? tgt_q : '0;
    assign up_sum   = {1'b0, ref_q} + {1'b0, stp_q};
    assign down_lim = {1'b0, floor_v} + {1'b0, stp_q};

    pwm_step_tick #(
        .WIDTH            (WIDTH),
        .PERIODS_PER_STEP (PERIODS_PER_STEP)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .ramp (ramp),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= ST_IDLE;
            ref_q  <= '0;
            tgt_q  <= '0;
            stp_q  <= '0;
            stop_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_n;
            ref_q  <= ref_n;
            tgt_q  <= tgt_n;
            stp_q  <= stp_n;
            stop_q <= stop_n;
            done_q <= done_n;
        end
    end

    // stop_q marks a RAMP_DOWN that is a soft-stop (en low) rather than a lowered target.
    always_comb begin
        st_n   = st_q;
        ref_n  = ref_q;
        tgt_n  = tgt_q;
        stp_n  = stp_q;
        stop_n = stop_q;
        done_n = 1'b0;
        if (fault) begin
            st_n   = ST_FAULT;
            ref_n  = '0;
            stop_n = 1'b0;
        end else begin
            case (st_q)
                ST_IDLE: begin
                    ref_n = '0;
                    if (en) begin
                        tgt_n = target;
                        stp_n = step_eff;
                        st_n  = ST_RAMP_UP;
                    end
                end
                ST_RAMP_UP: begin
                    if (!en) begin
                        st_n   = ST_RAMP_DOWN;
                        stop_n = 1'b1;
                    end else if (tick) begin
                        if (up_sum >= {1'b0, tgt_q}) begin
                            ref_n  = tgt_q;
                            st_n   = ST_HOLD;
                            done_n = 1'b1;
                        end else begin
                            ref_n = up_sum[WIDTH-1:0];
                        end
                    end
                end
                ST_HOLD: begin
                    if (!en) begin
                        st_n   = ST_RAMP_DOWN;
                        stop_n = 1'b1;
                    end else if (tick && (target != tgt_q)) begin
                        tgt_n  = target;
                        stp_n  = step_eff;
                        st_n   = (target > tgt_q) ? ST_RAMP_UP : ST_RAMP_DOWN;
                        stop_n = 1'b0;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (en && stop_q) begin
                        tgt_n  = target;
                        stp_n  = step_eff;
                        st_n   = ST_RAMP_UP;
                        stop_n = 1'b0;
                    end else begin
                        stop_n = stop_q | ~en;
                        if (tick) begin
                            if ({1'b0, ref_q} <= down_lim) begin
                                ref_n  = floor_v;
                                done_n = 1'b1;
                                st_n   = en ? ST_HOLD : ST_IDLE;
                                stop_n = 1'b0;
                            end else begin
                                ref_n = ref_q - stp_q;
                            end
                        end
                    end
                end
                ST_FAULT: begin
                    ref_n = '0;
                    if (!en) st_n = ST_IDLE;
                end
                default: begin
                    st_n  = ST_IDLE;
                    ref_n = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy = (st_q == ST_RAMP_UP) || (st_q == ST_RAMP_DOWN);
    end

    assign state   = st_q;
    assign ref_out = ref_q;
    assign done    = done_q;

endmodule

// File: doc/pwm_softstart_ctrl.md
PWM_SOFTSTART_CTRL -- requirements
Module: pwm_softstart_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the width of the ramp and the duty reference.
REQ-002 SHALL have parameter PERIODS_PER_STEP, default 4, the number of PWM periods between reference updates; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port en, input, 1 bit, level request to run the PWM output (1 = soft-start or hold, 0 = soft-stop).
REQ-006 SHALL have port target, input, WIDTH bits, the final duty reference.
REQ-007 SHALL have port step, input, WIDTH bits, the reference increment per update; the value 0 is treated as 1.
REQ-008 SHALL have port ramp, input, WIDTH bits, the sawtooth count from the PWM ramp generator.
REQ-009 SHALL have port fault, input, 1 bit, level fault request that forces immediate shutdown.
REQ-010 SHALL have port ref_out, output, WIDTH bits, the registered duty reference driven to the PWM comparator.
REQ-011 SHALL have port busy, output, 1 bit, high in RAMP_UP or RAMP_DOWN.
REQ-012 SHALL have port done, output, 1 bit, a 1-cycle pulse when ref_out first reaches the latched target or reaches 0 on soft-stop.
REQ-013 SHALL have port state, output, 3 bits, the current FSM state encoding.

Function
REQ-014 SHALL assert the period-end event in every cycle where ramp == all-ones (RAMP_MAX).
REQ-015 SHALL generate an update tick on every PERIODS_PER_STEP-th period-end; the tick counter runs only in RAMP_UP, RAMP_DOWN and HOLD and clears on entering any of them.
REQ-016 SHALL use the states IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3, FAULT=4.
REQ-017 In IDLE, ref_out SHALL be 0; en=1 with fault=0 SHALL latch target and step (tgt_l, stp_l) and enter RAMP_UP on the next edge.
REQ-018 In RAMP_UP, on each tick, ref_out SHALL become min(ref_out+stp_l, tgt_l), computed WIDTH+1 bits wide with no wrap; on reaching tgt_l the FSM SHALL enter HOLD and pulse done.
REQ-019 In HOLD, ref_out SHALL remain tgt_l; on a tick with target != tgt_l, the FSM SHALL re-latch target and step and enter RAMP_UP if the new value is higher, or RAMP_DOWN toward it if lower.
REQ-020 In RAMP_DOWN, on each tick, ref_out SHALL become max(ref_out-stp_l, floor) with no underflow; floor = 0 when en=0, else tgt_l.
REQ-021 On reaching floor in RAMP_DOWN, the FSM SHALL pulse done and enter IDLE when floor = 0 and en=0, or HOLD otherwise.
REQ-022 en=0 in RAMP_UP or HOLD SHALL enter RAMP_DOWN on the next edge without changing ref_out; the next tick applies the first decrement.
REQ-023 en=1 again during a soft-stop RAMP_DOWN SHALL re-latch target and enter RAMP_UP from the current ref_out.
REQ-024 fault=1 in any state SHALL enter FAULT and set ref_out=0 on the same edge; busy=0 and done=0 in FAULT.
REQ-025 FAULT SHALL exit to IDLE only when fault=0 and en=0 in the same cycle.
REQ-026 A latched target of 0 SHALL reach HOLD on the first tick with done pulsed.
REQ-027 When a tick coincides with an en or fault change, the state transition SHALL take priority, with the order fault > en > tick.
REQ-028 Changes on target or step outside the latch points SHALL be ignored.

Reset
REQ-029 On rst=1 at a clk edge, the block SHALL set state=IDLE, ref_out=0, busy=0, done=0, clear the tick counter and zero tgt_l and stp_l; reset mid-ramp SHALL abandon the ramp with no done pulse.

Structure
REQ-030 Package pwm_ctrl_pkg SHALL hold the state encoding constants and RAMP_MAX, shared with the ramp generator and the bench.
REQ-031 The period-end detector and divide-by-PERIODS_PER_STEP counter SHALL be one sub-module, pwm_step_tick (inputs clk, rst, run, ramp; output tick).

Verification
REQ-032 With target=0x80, step=0x20, PERIODS_PER_STEP=1 and en rising, ref_out SHALL step 0x20, 0x40, 0x60, 0x80 on four consecutive period-ends, then enter HOLD with one done pulse.
REQ-033 With target=0xF0 and step=0x30, ref_out SHALL saturate at 0xF0 with no wrap (0xC0 -> 0xF0, not 0x20 after 0xF0).
REQ-034 With HOLD at 0x80 and en dropped, ref_out SHALL decrement by step per tick to 0x00, then enter IDLE with a done pulse and busy=0.
REQ-035 fault asserted mid-RAMP_UP at ref_out=0x40 SHALL give ref_out=0 and state=4 on the next edge; releasing fault with en=1 SHALL keep FAULT, and en=0 SHALL move to IDLE.
REQ-036 rst pulsed in RAMP_DOWN SHALL give all outputs at reset values on the next edge with no done pulse; step=0 SHALL step by 1 per tick.
